// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave shifter and its synchronizers.
package spi_pkg;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Advance a byte-wide shift register by one bit in the selected direction.
    // MSB-first moves bits toward the MSB and inserts at bit 0; LSB-first moves
    // them toward the LSB and inserts at the MSB.
    function automatic logic [DATA_W-1:0] shift_one(
        input logic [DATA_W-1:0] value,
        input logic              lsb_first,
        input logic              fill
    );
        if (lsb_first)
            return {fill, value[DATA_W-1:1]};
        else
            return {value[DATA_W-2:0], fill};
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Flop-chain synchronizer for one asynchronous input, with a configurable
// reset value so idle levels are presented while in reset.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;
    logic [STAGES-1:0] chain_next;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign chain_next[gi] = d;
            end else begin : g_rest
                assign chain_next[gi] = chain_reg[gi-1];
            end
        end
    endgenerate

    // Shift the input through the chain every clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            chain_reg <= {STAGES{RST_VAL}};
        else
            chain_reg <= chain_next;
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave byte shifter: oversamples SCK/SS/MOSI in the clk domain, shifts a
// transmit byte out on MISO and assembles received bytes with SPIF/OVRF flags.
module spi_slave_shifter
    import spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SPE,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic              LSBFE,
    input  logic              SCK_in,
    input  logic              SS_slave,
    input  logic              Data_in,
    output logic              Data_out,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              SPIF,
    input  logic              spif_clr,
    output logic              OVRF,
    output logic              busy
);

    logic sck_s, ss_s, din_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst_n(rst_n), .d(SCK_in), .q(sck_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(SS_slave), .q(ss_s));
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst_n(rst_n), .d(Data_in), .q(din_s));

    state_t            state_reg, state_next;
    logic              sck_d_reg, ss_d_reg;
    logic              cpol_reg, cpha_reg, lsbfe_reg;
    logic [2:0]        bit_cnt_reg;
    logic [DATA_W-1:0] tx_shift_reg, rx_shift_reg, tx_buf_reg, rx_data_reg;
    logic              tx_ready_reg, spif_reg, ovrf_reg, done_reg;

    logic              sck_rise, sck_fall, lead_edge, trail_edge;
    logic              sample_edge, shift_edge, ss_fall;
    logic              start, active_run, last_sample, byte_start;
    logic [DATA_W-1:0] load_value;

    // Edge classification uses the mode captured at frame start.
    assign sck_rise    = sck_s & ~sck_d_reg;
    assign sck_fall    = ~sck_s & sck_d_reg;
    assign lead_edge   = cpol_reg ? sck_fall : sck_rise;
    assign trail_edge  = cpol_reg ? sck_rise : sck_fall;
    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    assign shift_edge  = cpha_reg ? lead_edge : trail_edge;
    assign ss_fall     = ss_d_reg & ~ss_s;

    assign start       = (state_reg == IDLE) && ss_fall && SPE;
    assign active_run  = (state_reg == ACTIVE) && SPE && !ss_s;
    assign last_sample = active_run && sample_edge && (bit_cnt_reg == 3'd7);
    assign byte_start  = start || last_sample;
    assign load_value  = tx_ready_reg ? '0 : tx_buf_reg;

    // Next-state logic: enter on SS fall, leave on SS rise or SPE drop.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ACTIVE;
            ACTIVE:  if (!SPE || ss_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Edge-detect history, mode capture, bit counter and shift registers.
    // A shift edge with the counter at 0 arrives before this byte's first
    // sample: with CPHA=1 that is the first leading edge, with CPHA=0 it is the
    // trailing edge that follows a byte boundary. Either way the freshly loaded
    // bit 0 must stay on the line, so the shift is suppressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_d_reg    <= 1'b0;
            ss_d_reg     <= 1'b1;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            lsbfe_reg    <= 1'b0;
            bit_cnt_reg  <= 3'd0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            sck_d_reg <= sck_s;
            ss_d_reg  <= ss_s;
            done_reg  <= 1'b0;
            if (start) begin
                cpol_reg     <= CPOL;
                cpha_reg     <= CPHA;
                lsbfe_reg    <= LSBFE;
                bit_cnt_reg  <= 3'd0;
                tx_shift_reg <= load_value;
            end else if (state_reg == ACTIVE) begin
                if (!active_run) begin
                    bit_cnt_reg <= 3'd0;
                end else if (sample_edge) begin
                    rx_shift_reg <= shift_one(rx_shift_reg, lsbfe_reg, din_s);
                    bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                    if (last_sample) begin
                        done_reg     <= 1'b1;
                        tx_shift_reg <= load_value;
                    end
                end else if (shift_edge && (bit_cnt_reg != 3'd0)) begin
                    tx_shift_reg <= shift_one(tx_shift_reg, lsbfe_reg, 1'b0);
                end
            end
        end
    end

    // Transmit buffer: writes accepted only when empty; byte start empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf_reg   <= '0;
            tx_ready_reg <= 1'b1;
        end else begin
            if (byte_start)
                tx_ready_reg <= 1'b1;
            if (tx_load && tx_ready_reg) begin
                tx_buf_reg   <= tx_data;
                tx_ready_reg <= 1'b0;
            end
        end
    end

    // Completion flags: a byte finishing while SPIF is still pending (and not
    // being cleared this cycle) is dropped and flagged as an overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_reg <= '0;
            spif_reg    <= 1'b0;
            ovrf_reg    <= 1'b0;
        end else if (done_reg) begin
            if (spif_reg && !spif_clr) begin
                ovrf_reg <= 1'b1;
            end else begin
                rx_data_reg <= rx_shift_reg;
                spif_reg    <= 1'b1;
                if (spif_clr)
                    ovrf_reg <= 1'b0;
            end
        end else if (spif_clr) begin
            spif_reg <= 1'b0;
            ovrf_reg <= 1'b0;
        end
    end

    assign busy     = (state_reg == ACTIVE);
    assign Data_out = busy ? (lsbfe_reg ? tx_shift_reg[0] : tx_shift_reg[DATA_W-1]) : 1'b0;
    assign tx_ready = tx_ready_reg;
    assign rx_data  = rx_data_reg;
    assign SPIF     = spif_reg;
    assign OVRF     = ovrf_reg;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Self-checking bench for spi_slave_shifter: acts as SPI master, scoreboards
// received bytes and MISO bytes, and checks the flag behaviour.
module tb_spi_slave_shifter;

    localparam int H = 8;   // SCK half period in clk cycles (16x oversampling)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       SPE = 1'b1;
    logic       CPOL = 1'b0;
    logic       CPHA = 1'b0;
    logic       LSBFE = 1'b0;
    logic       SCK_in = 1'b0;
    logic       SS_slave = 1'b1;
    logic       Data_in = 1'b0;
    logic       Data_out;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       SPIF;
    logic       spif_clr = 1'b0;
    logic       OVRF;
    logic       busy;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_rx_q[$];
    logic [7:0] exp_miso_q[$];

    spi_slave_shifter dut (
        .clk(clk), .rst_n(rst_n), .SPE(SPE), .CPOL(CPOL), .CPHA(CPHA),
        .LSBFE(LSBFE), .SCK_in(SCK_in), .SS_slave(SS_slave), .Data_in(Data_in),
        .Data_out(Data_out), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .rx_data(rx_data), .SPIF(SPIF),
        .spif_clr(spif_clr), .OVRF(OVRF), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait one SCK half period; optionally pulse spif_clr so that it lands
    // in the cycle where the slave reports a byte finished at the preceding
    // SCK toggle (2 sync flops + edge detect + completion register).
    task automatic half_wait(input bit pulse_clr);
        for (int c = 0; c < H; c++) begin
            @(negedge clk);
            spif_clr = pulse_clr && (c == 2);
        end
        spif_clr = 1'b0;
    endtask

    task automatic set_mode(input logic cpol, input logic cpha, input logic lsbfe);
        @(negedge clk);
        CPOL = cpol; CPHA = cpha; LSBFE = lsbfe; SCK_in = cpol;
        repeat (H) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data = b; tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); spif_clr = 1'b1;
        @(negedge clk); spif_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic ss_low();
        @(negedge clk);
        SS_slave = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (H) @(negedge clk);
        SS_slave = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    // Master side of nbits SCK cycles in the current mode.
    task automatic xfer(input logic [7:0] mosi, input int nbits, input bit clr_at_end,
                        output logic [7:0] miso);
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            bit last;
            idx  = LSBFE ? i : 7 - i;
            last = clr_at_end && (i == nbits - 1);
            if (!CPHA) begin
                Data_in = mosi[idx];
                half_wait(1'b0);
                miso[idx] = Data_out;
                SCK_in = ~CPOL;
                half_wait(last);
                SCK_in = CPOL;
            end else begin
                SCK_in = ~CPOL;
                Data_in = mosi[idx];
                half_wait(1'b0);
                miso[idx] = Data_out;
                SCK_in = CPOL;
                half_wait(last);
            end
        end
        if (!CPHA) half_wait(1'b0);
        $display("xfer mosi=%02h bits=%0d miso=%02h", mosi, nbits, miso);
    endtask

    task automatic test_reset();
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%02h exp=00", rx_data); end
        checks++; if (SPIF !== 1'b0) begin failures++; $display("FAIL reset_spif got=%b exp=0", SPIF); end
        checks++; if (OVRF !== 1'b0) begin failures++; $display("FAIL reset_ovrf got=%b exp=0", OVRF); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (Data_out !== 1'b0) begin failures++; $display("FAIL reset_data_out got=%b exp=0", Data_out); end
    endtask

    task automatic test_mode0();
        logic [7:0] miso, e;
        set_mode(1'b0, 1'b0, 1'b0);
        load_tx(8'h3C);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL m0_tx_ready_loaded got=%b exp=0", tx_ready); end
        exp_rx_q.push_back(8'hA5); exp_miso_q.push_back(8'h3C);
        ss_low();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL m0_busy got=%b exp=1", busy); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL m0_tx_ready_start got=%b exp=1", tx_ready); end
        xfer(8'hA5, 8, 1'b0, miso);
        e = exp_rx_q.pop_front();
        checks++; if (rx_data !== e) begin failures++; $display("FAIL m0_rx_data got=%02h exp=%02h", rx_data, e); end
        e = exp_miso_q.pop_front();
        checks++; if (miso !== e) begin failures++; $display("FAIL m0_miso got=%02h exp=%02h", miso, e); end
        checks++; if (SPIF !== 1'b1) begin failures++; $display("FAIL m0_spif got=%b exp=1", SPIF); end
        ss_high();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL m0_busy_end got=%b exp=0", busy); end
        pulse_clr();
        checks++; if (SPIF !== 1'b0) begin failures++; $display("FAIL m0_spif_clr got=%b exp=0", SPIF); end
    endtask

    task automatic test_mode3_lsb();
        logic [7:0] miso, e;
        set_mode(1'b1, 1'b1, 1'b1);
        load_tx(8'h55);
        exp_rx_q.push_back(8'h81); exp_miso_q.push_back(8'h55);
        exp_rx_q.push_back(8'h7E); exp_miso_q.push_back(8'hAA);
        ss_low();
        load_tx(8'hAA);
        checks++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL m3_tx_ready_mid got=%b exp=0", tx_ready); end
        xfer(8'h81, 8, 1'b0, miso);
        e = exp_rx_q.pop_front();
        checks++; if (rx_data !== e) begin failures++; $display("FAIL m3_rx1 got=%02h exp=%02h", rx_data, e); end
        e = exp_miso_q.pop_front();
        checks++; if (miso !== e) begin failures++; $display("FAIL m3_miso1 got=%02h exp=%02h", miso, e); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL m3_tx_ready_boundary got=%b exp=1", tx_ready); end
        pulse_clr();
        xfer(8'h7E, 8, 1'b0, miso);
        e = exp_rx_q.pop_front();
        checks++; if (rx_data !== e) begin failures++; $display("FAIL m3_rx2 got=%02h exp=%02h", rx_data, e); end
        e = exp_miso_q.pop_front();
        checks++; if (miso !== e) begin failures++; $display("FAIL m3_miso2 got=%02h exp=%02h", miso, e); end
        checks++; if (OVRF !== 1'b0) begin failures++; $display("FAIL m3_ovrf got=%b exp=0", OVRF); end
        ss_high();
        pulse_clr();
    endtask

    task automatic test_overrun();
        logic [7:0] miso, e;
        set_mode(1'b0, 1'b0, 1'b0);
        exp_rx_q.push_back(8'h11);
        exp_miso_q.push_back(8'h00); exp_miso_q.push_back(8'h00);
        ss_low();
        xfer(8'h11, 8, 1'b0, miso);
        e = exp_miso_q.pop_front();
        checks++; if (miso !== e) begin failures++; $display("FAIL ovr_miso1 got=%02h exp=%02h", miso, e); end
        xfer(8'h22, 8, 1'b0, miso);
        e = exp_miso_q.pop_front();
        checks++; if (miso !== e) begin failures++; $display("FAIL ovr_miso2 got=%02h exp=%02h", miso, e); end
        ss_high();
        e = exp_rx_q.pop_front();
        checks++; if (rx_data !== e) begin failures++; $display("FAIL ovr_rx_kept got=%02h exp=%02h", rx_data, e); end
        checks++; if (OVRF !== 1'b1) begin failures++; $display("FAIL ovr_ovrf got=%b exp=1", OVRF); end
        checks++; if (SPIF !== 1'b1) begin failures++; $display("FAIL ovr_spif got=%b exp=1", SPIF); end
        pulse_clr();
        checks++; if (SPIF !== 1'b0) begin failures++; $display("FAIL ovr_spif_clr got=%b exp=0", SPIF); end
        checks++; if (OVRF !== 1'b0) begin failures++; $display("FAIL ovr_ovrf_clr got=%b exp=0", OVRF); end
    endtask

    task automatic test_clr_coincident();
        logic [7:0] miso, e;
        exp_rx_q.push_back(8'h33); exp_rx_q.push_back(8'h44);
        ss_low();
        xfer(8'h33, 8, 1'b0, miso);
        e = exp_rx_q.pop_front();
        checks++; if (rx_data !== e) begin failures++; $display("FAIL coin_rx1 got=%02h exp=%02h", rx_data, e); end
        xfer(8'h44, 8, 1'b1, miso);
        ss_high();
        e = exp_rx_q.pop_front();
        checks++; if (rx_data !== e) begin failures++; $display("FAIL coin_rx2 got=%02h exp=%02h", rx_data, e); end
        checks++; if (SPIF !== 1'b1) begin failures++; $display("FAIL coin_spif got=%b exp=1", SPIF); end
        checks++; if (OVRF !== 1'b0) begin failures++; $display("FAIL coin_ovrf got=%b exp=0", OVRF); end
    endtask

    task automatic test_abort();
        logic [7:0] miso, e;
        // SPIF is still set with 0x44 from the previous scenario.
        ss_low();
        xfer(8'hFF, 5, 1'b0, miso);
        @(negedge clk); SS_slave = 1'b1;
        repeat (H) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (SPIF !== 1'b1) begin failures++; $display("FAIL abort_spif got=%b exp=1", SPIF); end
        checks++; if (rx_data !== 8'h44) begin failures++; $display("FAIL abort_rx got=%02h exp=44", rx_data); end
        pulse_clr();
        exp_rx_q.push_back(8'h12);
        ss_low();
        xfer(8'h12, 8, 1'b0, miso);
        ss_high();
        e = exp_rx_q.pop_front();
        checks++; if (rx_data !== e) begin failures++; $display("FAIL abort_next_rx got=%02h exp=%02h", rx_data, e); end
        checks++; if (SPIF !== 1'b1) begin failures++; $display("FAIL abort_next_spif got=%b exp=1", SPIF); end
        pulse_clr();
    endtask

    task automatic test_reset_mid();
        logic [7:0] miso, e;
        ss_low();
        load_tx(8'h99);
        xfer(8'h00, 3, 1'b0, miso);
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL rstm_rx got=%02h exp=00", rx_data); end
        checks++; if (SPIF !== 1'b0) begin failures++; $display("FAIL rstm_spif got=%b exp=0", SPIF); end
        checks++; if (OVRF !== 1'b0) begin failures++; $display("FAIL rstm_ovrf got=%b exp=0", OVRF); end
        checks++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL rstm_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstm_busy got=%b exp=0", busy); end
        checks++; if (Data_out !== 1'b0) begin failures++; $display("FAIL rstm_data_out got=%b exp=0", Data_out); end
        SS_slave = 1'b1; SCK_in = CPOL;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (H) @(negedge clk);
        exp_rx_q.push_back(8'hF0);
        ss_low();
        xfer(8'hF0, 8, 1'b0, miso);
        ss_high();
        e = exp_rx_q.pop_front();
        checks++; if (rx_data !== e) begin failures++; $display("FAIL rstm_next_rx got=%02h exp=%02h", rx_data, e); end
        checks++; if (SPIF !== 1'b1) begin failures++; $display("FAIL rstm_next_spif got=%b exp=1", SPIF); end
    endtask

    initial begin
        repeat (5) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_mode0();
        test_mode3_lsb();
        test_overrun();
        test_clr_coincident();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
